shifter_arbiter: RTL

- Shares one combinational shifter datapath (SLL/SRL/SRA, 5-bit shift amount) between NUM_REQ requesters.
- Example requesters: the ALU shift path, the CSR/bit-manipulation helper and the multi-cycle multiply/divide sequencer.
- Round-robin arbitration with a valid/ready handshake per requester; one registered response slot carries the result and the winning requester ID.
- Sits between the requesters and the writeback muxes; it is the only instantiator of the shared shifter in the core.

---
 rtl/shift_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/shifter.sv | 21 ++
 rtl/shifter_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift op encoding and datapath widths
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_RSV = 2'b11
  } shift_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting the search at ptr
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant
);

  logic found;

  // Walk offsets 0..N-1 from ptr; the inner loop picks the requester at that offset.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int j = 0; j < N; j++) begin
        if (en && !found && valid[j] && (j == ((int'(ptr) + off) % N))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shifter.sv
// rtl/shifter.sv - combinational SLL/SRL/SRA shifter, reserved op yields zero
module shifter
  import shift_pkg::*;
(
  input  shift_op_e          op,
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] sh,
  output logic [XLEN-1:0]    result
);

  always_comb begin
    result = '0;
    case (op)
      SHIFT_SLL: result = a << sh;
      SHIFT_SRL: result = a >> sh;
      SHIFT_SRA: result = $signed(a) >>> sh;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - shares one shifter among NUM_REQ requesters with a registered response slot
module shifter_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [2*NUM_REQ-1:0]   i_req_sel,
  input  logic [32*NUM_REQ-1:0]  i_req_a,
  input  logic [32*NUM_REQ-1:0]  i_req_b,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [XLEN-1:0]        o_rsp_data,
  output logic [ID_W-1:0]        o_rsp_id
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    nxt_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               slot_free;
  shift_op_e          mux_op;
  logic [XLEN-1:0]    mux_a;
  logic [SHAMT_W-1:0] mux_sh;
  logic [XLEN-1:0]    shift_res;
  logic               unused_b_hi;

  // Only b[4:0] of each requester feeds the shifter.
  assign unused_b_hi = ^i_req_b;

  assign slot_free = !o_rsp_valid || i_rsp_ready;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_rr_arbiter (
    .valid (i_req_valid),
    .ptr   (rr_ptr),
    .en    (slot_free && i_rst_n),
    .grant (grant)
  );

  assign o_req_ready = grant;

  always_comb begin
    gnt_id  = '0;
    nxt_ptr = '0;
    mux_op  = SHIFT_SLL;
    mux_a   = '0;
    mux_sh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        gnt_id  = ID_W'(k);
        nxt_ptr = ID_W'((k + 1) % NUM_REQ);
        mux_op  = shift_op_e'(i_req_sel[2*k +: 2]);
        mux_a   = i_req_a[32*k +: 32];
        mux_sh  = i_req_b[32*k +: SHAMT_W];
      end
    end
  end

  shifter u_shifter (
    .op     (mux_op),
    .a      (mux_a),
    .sh     (mux_sh),
    .result (shift_res)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= '0;
      rr_ptr      <= '0;
    end else if (|grant) begin
      o_rsp_valid <= 1'b1;
      o_rsp_data  <= shift_res;
      o_rsp_id    <= gnt_id;
      rr_ptr      <= nxt_ptr;
    end else if (i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule
